// File: rtl/vxm_result_led_sequencer_if.sv
// Result-in / LED-out bundle between the VXM result source and the LED sequencer.
interface vxm_result_led_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    logic                     res_valid;
    logic [DATA_W-1:0]        res_data;
    logic [7:0]               leds;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [7:0]               drop_cnt;

    modport master (
        output res_valid, res_data,
        input  leds, busy, fifo_level, drop_cnt
    );
    modport slave (
        input  res_valid, res_data,
        output leds, busy, fifo_level, drop_cnt
    );
endinterface

// File: rtl/vxm_result_led_sequencer.sv
// Buffers VXM results in a small FIFO and shows each on LD7..LD0 for a dwell time, then a blank gap.
// Optional: define LED_HEARTBEAT_EN to blink leds[0] every DWELL_CYCLES while idle and empty.
module vxm_result_led_sequencer #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 8,
    parameter int DWELL_CYCLES = 100000000,
    parameter int GAP_CYCLES   = 10000000
) (
    input  logic                          clk,
    input  logic                          rst,
    vxm_result_led_sequencer_if.slave     bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW      = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Only the LED image of each word is kept, so the FIFO is 8 bits wide.
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_drop;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_leds;

    logic       w_empty;
    logic       w_full;
    logic       w_cnt_zero;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [7:0] w_in_leds;
    logic [7:0] w_head;
    logic       w_unused_data;

    assign w_in_leds     = {bus.res_data[31], bus.res_data[6:0]};
    assign w_unused_data = ^bus.res_data[30:7];
    assign w_head        = r_mem[r_rd_ptr];
    assign w_empty       = (r_level == '0);
    assign w_full        = (r_level == LW'(DEPTH));
    assign w_cnt_zero    = (r_cnt == '0);

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = !w_empty;
            ST_SHOW: w_pop = w_cnt_zero && (GAP_CYCLES == 0) && !w_empty;
            ST_GAP:  w_pop = w_cnt_zero && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_push = bus.res_valid && (!w_full || w_pop);
    assign w_drop = bus.res_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in_leds;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= DWELL_LOAD;
            r_leds  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_leds  <= w_head;
                        r_cnt   <= DWELL_LOAD;
                        r_state <= ST_SHOW;
                    end
`ifdef LED_HEARTBEAT_EN
                    else if (w_cnt_zero) begin
                        r_leds <= {7'd0, ~r_leds[0]};
                        r_cnt  <= DWELL_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
`endif
                end
                ST_SHOW: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (GAP_CYCLES > 0) begin
                        r_leds  <= '0;
                        r_cnt   <= GAP_LOAD;
                        r_state <= ST_GAP;
                    end else if (w_pop) begin
                        r_leds <= w_head;
                        r_cnt  <= DWELL_LOAD;
                    end else begin
                        // No gap configured: the last word stays lit while idle.
                        r_cnt   <= DWELL_LOAD;
                        r_state <= ST_IDLE;
`ifdef LED_HEARTBEAT_EN
                        r_leds  <= '0;
`endif
                    end
                end
                ST_GAP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (w_pop) begin
                        r_leds  <= w_head;
                        r_cnt   <= DWELL_LOAD;
                        r_state <= ST_SHOW;
                    end else begin
                        r_leds  <= '0;
                        r_cnt   <= DWELL_LOAD;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_leds  <= '0;
                    r_cnt   <= DWELL_LOAD;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.leds       = r_leds;
    assign bus.fifo_level = r_level;
    assign bus.drop_cnt   = r_drop;
    assign bus.busy       = (r_state != ST_IDLE) | (r_level != '0);
endmodule

// File: tb/tb_vxm_result_led_sequencer.sv
// Randomized bench: a timeline model of slots and a queue predicts LEDs, level, drops and busy.
module tb_vxm_result_led_sequencer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int DWELL = 4;
    localparam int GAP   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vxm_result_led_sequencer_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    vxm_result_led_sequencer #(
        .DATA_W(DW), .DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAP)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] led_of(input logic [31:0] w);
        return {w[31], w[6:0]};
    endfunction

    // Reference model: each pop claims a DWELL+GAP slot; the next pop may not come earlier.
    logic [31:0] mq[$];
    logic [7:0]  sb[$];
    int          ed;
    int          next_pop;
    int          show_end;
    logic [7:0]  m_leds;
    int          m_drop;
    bit          m_busy;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                sb.delete();
                ed = 0; next_pop = 0; show_end = -1;
                m_leds = 8'h00; m_drop = 0;
            end else begin
                ed++;
                if (ed == show_end) m_leds = 8'h00;
                if (mq.size() > 0 && ed >= next_pop) begin
                    m_leds   = led_of(mq.pop_front());
                    show_end = ed + DWELL;
                    next_pop = ed + DWELL + GAP;
                end
                if (bus.res_valid) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(bus.res_data);
                        sb.push_back(led_of(bus.res_data));
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end
            end
            m_busy = (mq.size() > 0) || (ed < next_pop);
        end
    end

    // Monitor: per-cycle state checks plus in-order word/dwell checks at display edges.
    logic [7:0] prev_leds = 8'h00;
    int         on_run = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_leds = 8'h00;
                on_run = 0;
            end else begin
                chk("leds", int'(bus.leds), int'(m_leds));
                chk("fifo_level", int'(bus.fifo_level), mq.size());
                chk("drop_cnt", int'(bus.drop_cnt), m_drop);
                chk("busy", int'(bus.busy), int'(m_busy));
                if (prev_leds == 8'h00 && bus.leds != 8'h00) begin
                    if (sb.size() == 0) chk("sb_underflow", int'(bus.leds), 0);
                    else chk("sb_word", int'(bus.leds), int'(sb.pop_front()));
                end
                if (bus.leds != 8'h00) on_run++;
                else if (on_run != 0) begin
                    chk("dwell_len", on_run, DWELL);
                    on_run = 0;
                end
                prev_leds = bus.leds;
            end
        end
    end

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (led_of(w) == 8'h00) w[0] = 1'b1;
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.res_valid = v;
        bus.res_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0);
    endtask

    task automatic rand_phase(input int n, input int pct);
        for (int i = 0; i < n; i++)
            drive(($urandom_range(99) < pct), rnd_word());
    endtask

    initial begin
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        #23;
        chk("rst_leds", int'(bus.leds), 0);
        chk("rst_level", int'(bus.fifo_level), 0);
        chk("rst_drop", int'(bus.drop_cnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Single word with explicit latency checks.
        drive(1'b1, 32'h8000_0055);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        @(negedge clk);
        chk("lat_edgeN", int'(bus.leds), 0);
        @(negedge clk);
        chk("lat_edgeN1", int'(bus.leds), 8'hD5);
        idle(12);

        // Burst of four, then six back-to-back (one must drop).
        for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i));
        idle(30);
        for (int i = 0; i < 6; i++) drive(1'b1, 32'h10 + 32'(i));
        idle(40);
        chk("drop_after_six", int'(bus.drop_cnt), 1);

        // Continuous strobes saturate drop_cnt and exercise full+pop.
        for (int i = 0; i < 2000; i++) drive(1'b1, rnd_word());
        idle(1);
        chk("drop_sat", int'(bus.drop_cnt), 255);
        idle(40);

        rand_phase(800, 20);
        rand_phase(400, 60);
        idle(40);

        // Asynchronous reset in the middle of a dwell.
        rand_phase(3, 100);
        drive(1'b0, 32'h0);
        begin
            int k = 0;
            while (bus.leds == 8'h00 && k < 50) begin @(negedge clk); k++; end
            chk("wait_show", int'(k < 50), 1);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_leds", int'(bus.leds), 0);
        chk("arst_level", int'(bus.fifo_level), 0);
        chk("arst_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(10);
        chk("post_rst_drop", int'(bus.drop_cnt), 0);

        rand_phase(400, 30);
        idle(60);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
